// File: rtl/issue_sched.sv
// issue_sched: 8-entry age-matrix issue queue with tag wakeup and oldest-first single-issue select.
// Define ISSUE_WAKEUP_BYPASS_EN to let a same-cycle writeback tag satisfy select requests.
module issue_sched #(
    parameter int IQ_DEPTH = 8,
    parameter int PREG_W   = 7,
    parameter int ROB_W    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq_valid,
    input  logic [PREG_W-1:0]             enq_P_rs1,
    input  logic [PREG_W-1:0]             enq_P_rs2,
    input  logic [PREG_W-1:0]             enq_P_rd,
    input  logic                          enq_rs1_rdy,
    input  logic                          enq_rs2_rdy,
    input  logic [2:0]                    enq_fu_sel,
    input  logic [ROB_W-1:0]              enq_rob_idx,
    output logic                          IS_ready,
    input  logic                          wb_valid,
    input  logic [PREG_W-1:0]             wb_P_rd,
    input  logic [7:0]                    fu_ready,
    input  logic                          issue_ready,
    output logic                          issue_valid,
    output logic [PREG_W-1:0]             issue_P_rs1,
    output logic [PREG_W-1:0]             issue_P_rs2,
    output logic [PREG_W-1:0]             issue_P_rd,
    output logic [2:0]                    issue_fu_sel,
    output logic [ROB_W-1:0]              issue_rob_idx,
    input  logic                          mispredict,
    output logic [$clog2(IQ_DEPTH):0]     iq_count
);
    localparam int IW = $clog2(IQ_DEPTH);
    localparam int CW = IW + 1;
`ifdef ISSUE_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [IQ_DEPTH-1:0] valid, rs1_rdy, rs2_rdy;
    logic [PREG_W-1:0]   p_rs1 [IQ_DEPTH];
    logic [PREG_W-1:0]   p_rs2 [IQ_DEPTH];
    logic [PREG_W-1:0]   p_rd  [IQ_DEPTH];
    logic [2:0]          fu    [IQ_DEPTH];
    logic [ROB_W-1:0]    rob   [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] age   [IQ_DEPTH];
    logic [CW-1:0]       cnt;
    logic [IQ_DEPTH-1:0] rdy1, rdy2, req, gnt;
    logic [IW-1:0]       gidx, slot;
    logic                enq, deq, e_r1, e_r2;

    always_comb begin
        rdy1 = '0;
        rdy2 = '0;
        req  = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            rdy1[i] = rs1_rdy[i] | (BYP & wb_valid & (p_rs1[i] == wb_P_rd));
            rdy2[i] = rs2_rdy[i] | (BYP & wb_valid & (p_rs2[i] == wb_P_rd));
            req[i]  = valid[i] & rdy1[i] & rdy2[i] & fu_ready[fu[i]];
        end
    end

    // An entry wins only if no older entry is also requesting.
    always_comb begin
        gnt  = req;
        gidx = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            for (int j = 0; j < IQ_DEPTH; j++)
                if (req[j] && age[j][i]) gnt[i] = 1'b0;
            if (gnt[i]) gidx = IW'(i);
        end
    end

    always_comb begin
        slot = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--)
            if (!valid[i]) slot = IW'(i);
    end

    assign issue_valid   = |req;
    assign deq           = issue_valid & issue_ready;
    assign IS_ready      = cnt != CW'(IQ_DEPTH);
    assign enq           = enq_valid & IS_ready;
    assign iq_count      = cnt;
    assign e_r1          = enq_rs1_rdy | (enq_P_rs1 == '0) | (wb_valid && enq_P_rs1 == wb_P_rd);
    assign e_r2          = enq_rs2_rdy | (enq_P_rs2 == '0) | (wb_valid && enq_P_rs2 == wb_P_rd);
    assign issue_P_rs1   = issue_valid ? p_rs1[gidx] : '0;
    assign issue_P_rs2   = issue_valid ? p_rs2[gidx] : '0;
    assign issue_P_rd    = issue_valid ? p_rd[gidx]  : '0;
    assign issue_fu_sel  = issue_valid ? fu[gidx]    : '0;
    assign issue_rob_idx = issue_valid ? rob[gidx]   : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= '0;
            rs1_rdy <= '0;
            rs2_rdy <= '0;
            cnt     <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                p_rs1[i] <= '0;
                p_rs2[i] <= '0;
                p_rd[i]  <= '0;
                fu[i]    <= '0;
                rob[i]   <= '0;
                age[i]   <= '0;
            end
        end else if (mispredict) begin
            valid <= '0;
            cnt   <= '0;
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (wb_valid && p_rs1[i] == wb_P_rd) rs1_rdy[i] <= 1'b1;
                if (wb_valid && p_rs2[i] == wb_P_rd) rs2_rdy[i] <= 1'b1;
            end
            if (deq) valid[gidx] <= 1'b0;
            // New entry is younger than everything currently held.
            if (enq) begin
                valid[slot]   <= 1'b1;
                rs1_rdy[slot] <= e_r1;
                rs2_rdy[slot] <= e_r2;
                p_rs1[slot]   <= enq_P_rs1;
                p_rs2[slot]   <= enq_P_rs2;
                p_rd[slot]    <= enq_P_rd;
                fu[slot]      <= enq_fu_sel;
                rob[slot]     <= enq_rob_idx;
                age[slot]     <= '0;
                for (int i = 0; i < IQ_DEPTH; i++)
                    if (valid[i]) age[i][slot] <= 1'b1;
            end
            cnt <= cnt + CW'(enq) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed vector table, corner sequences and random traffic against an in-order queue model.
module tb_issue_sched;
`ifdef ISSUE_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic       enq_valid, enq_rs1_rdy, enq_rs2_rdy, IS_ready, wb_valid, issue_ready, issue_valid, mispredict;
    logic [6:0] enq_P_rs1, enq_P_rs2, enq_P_rd, wb_P_rd, issue_P_rs1, issue_P_rs2, issue_P_rd;
    logic [2:0] enq_fu_sel, enq_rob_idx, issue_fu_sel, issue_rob_idx;
    logic [7:0] fu_ready;
    logic [3:0] iq_count;

    issue_sched dut (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_P_rs1(enq_P_rs1), .enq_P_rs2(enq_P_rs2),
        .enq_P_rd(enq_P_rd), .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy), .enq_fu_sel(enq_fu_sel),
        .enq_rob_idx(enq_rob_idx), .IS_ready(IS_ready), .wb_valid(wb_valid), .wb_P_rd(wb_P_rd),
        .fu_ready(fu_ready), .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_P_rs1(issue_P_rs1),
        .issue_P_rs2(issue_P_rs2), .issue_P_rd(issue_P_rd), .issue_fu_sel(issue_fu_sel),
        .issue_rob_idx(issue_rob_idx), .mispredict(mispredict), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] rs1, rs2, rd;
        logic       r1, r2;
        logic [2:0] fu, rob;
    } ent_t;

    typedef struct packed {
        logic       ev;
        logic [6:0] rs1, rs2, rd;
        logic       r1, r2;
        logic [2:0] fu, rob;
        logic       wbv;
        logic [6:0] wbt;
        logic [7:0] fur;
        logic       ir, mp, xv;
        logic [2:0] xrob;
        logic [3:0] xcnt;
    } vec_t;

    ent_t q[$];
    vec_t tbl[$];
    int   msel;
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int ev, int rs1, int rs2, int rd, int r1, int r2, int fu, int rob,
                                int wbv, int wbt, int fur, int ir, int mp, int xv, int xrob, int xcnt);
        vec_t v;
        v.ev = 1'(ev); v.rs1 = 7'(rs1); v.rs2 = 7'(rs2); v.rd = 7'(rd); v.r1 = 1'(r1); v.r2 = 1'(r2);
        v.fu = 3'(fu); v.rob = 3'(rob); v.wbv = 1'(wbv); v.wbt = 7'(wbt); v.fur = 8'(fur);
        v.ir = 1'(ir); v.mp = 1'(mp); v.xv = 1'(xv); v.xrob = 3'(xrob); v.xcnt = 4'(xcnt);
        return v;
    endfunction

    task automatic idle();
        enq_valid = 0; enq_P_rs1 = 0; enq_P_rs2 = 0; enq_P_rd = 0; enq_rs1_rdy = 0; enq_rs2_rdy = 0;
        enq_fu_sel = 0; enq_rob_idx = 0; wb_valid = 0; wb_P_rd = 0; fu_ready = 8'hff;
        issue_ready = 1; mispredict = 0;
    endtask

    task automatic enq_set(input int rs1, input int rs2, input int rd, input int r1, input int r2,
                           input int fu, input int rob);
        enq_valid = 1; enq_P_rs1 = 7'(rs1); enq_P_rs2 = 7'(rs2); enq_P_rd = 7'(rd);
        enq_rs1_rdy = 1'(r1); enq_rs2_rdy = 1'(r2); enq_fu_sel = 3'(fu); enq_rob_idx = 3'(rob);
    endtask

    // Oldest ready entry in queue order whose FU is free is the expected issue.
    task automatic look();
        logic a, b;
        #1;
        msel = -1;
        for (int k = 0; k < q.size(); k++) begin
            a = q[k].r1 || (BYP && wb_valid && q[k].rs1 == wb_P_rd);
            b = q[k].r2 || (BYP && wb_valid && q[k].rs2 == wb_P_rd);
            if (msel < 0 && a && b && fu_ready[q[k].fu]) msel = k;
        end
        chk("issue_valid", issue_valid, 32'(msel >= 0));
        if (msel >= 0) begin
            chk("issue_P_rs1", issue_P_rs1, q[msel].rs1);
            chk("issue_P_rs2", issue_P_rs2, q[msel].rs2);
            chk("issue_P_rd", issue_P_rd, q[msel].rd);
            chk("issue_fu_sel", issue_fu_sel, q[msel].fu);
            chk("issue_rob_idx", issue_rob_idx, q[msel].rob);
        end else begin
            chk("issue_fields_zero", {issue_P_rs1, issue_P_rs2, issue_P_rd, issue_fu_sel, issue_rob_idx}, 0);
        end
        chk("iq_count", iq_count, q.size());
        chk("IS_ready", IS_ready, 32'(q.size() != 8));
    endtask

    task automatic tick();
        ent_t e;
        bit   full;
        @(posedge clk);
        if (mispredict) q.delete();
        else begin
            full = q.size() == 8;
            foreach (q[k]) begin
                if (wb_valid && q[k].rs1 == wb_P_rd) q[k].r1 = 1;
                if (wb_valid && q[k].rs2 == wb_P_rd) q[k].r2 = 1;
            end
            if (msel >= 0 && issue_ready) q.delete(msel);
            if (enq_valid && !full) begin
                e.rs1 = enq_P_rs1; e.rs2 = enq_P_rs2; e.rd = enq_P_rd; e.fu = enq_fu_sel; e.rob = enq_rob_idx;
                e.r1 = enq_rs1_rdy || enq_P_rs1 == 0 || (wb_valid && enq_P_rs1 == wb_P_rd);
                e.r2 = enq_rs2_rdy || enq_P_rs2 == 0 || (wb_valid && enq_P_rs2 == wb_P_rd);
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1;
        #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_iq_count", iq_count, 0);
        chk("rst_IS_ready", IS_ready, 1);
        chk("rst_issue_rob", issue_rob_idx, 0);
        q.delete();
        @(negedge clk);
        rst = 0;
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        //      ev rs1 rs2 rd r1 r2 fu rob wbv wbt fur    ir mp xv xrob xcnt
        tbl.push_back(mk(1, 1, 2, 10, 1, 1, 0, 2, 0, 0,  'h02, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 11, 1, 1, 0, 3, 0, 0,  'h02, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 3, 4, 12, 1, 1, 1, 4, 0, 0,  'h02, 1, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'h02, 1, 0, 1, 4, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'h01, 1, 0, 1, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'h01, 1, 0, 1, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'h01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 17, 20, 1, 0, 0, 5, 1, 17, 'hff, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'hff, 1, 0, 1, 5, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'hff, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6, 7, 30, 1, 1, 0, 0, 0, 0,  'hff, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6, 7, 31, 1, 1, 0, 1, 0, 0,  'hff, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 6, 7, 32, 1, 1, 0, 2, 0, 0,  'hff, 0, 0, 1, 0, 2));
        tbl.push_back(mk(1, 6, 7, 33, 1, 1, 0, 3, 0, 0,  'hff, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'hff, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'hff, 0, 0, 1, 0, 4));
        tbl.push_back(mk(1, 8, 9, 40, 1, 1, 0, 6, 0, 0,  'hff, 1, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'hff, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 41, 0, 0, 3, 7, 0, 0,  'hff, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'hff, 1, 0, 1, 7, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  'hff, 1, 0, 0, 0, 0));

        foreach (tbl[r]) begin
            enq_valid = tbl[r].ev; enq_P_rs1 = tbl[r].rs1; enq_P_rs2 = tbl[r].rs2; enq_P_rd = tbl[r].rd;
            enq_rs1_rdy = tbl[r].r1; enq_rs2_rdy = tbl[r].r2; enq_fu_sel = tbl[r].fu; enq_rob_idx = tbl[r].rob;
            wb_valid = tbl[r].wbv; wb_P_rd = tbl[r].wbt; fu_ready = tbl[r].fur;
            issue_ready = tbl[r].ir; mispredict = tbl[r].mp;
            look();
            chk("tbl_issue_valid", issue_valid, tbl[r].xv);
            if (tbl[r].xv) chk("tbl_issue_rob", issue_rob_idx, tbl[r].xrob);
            chk("tbl_iq_count", iq_count, tbl[r].xcnt);
            tick();
        end
        idle();

        // Wakeup of a stored entry
        enq_set(40, 1, 70, 0, 1, 0, 1);
        look(); tick();
        idle();
        look(); chk("wake_before", issue_valid, 0); tick();
        wb_valid = 1; wb_P_rd = 40;
        look(); chk("wake_same_cycle", issue_valid, 32'(BYP)); tick();
        idle();
        look(); chk("wake_next_cycle", issue_valid, 32'(!BYP)); tick();
        look(); tick();

        // Full queue
        for (int i = 0; i < 8; i++) begin
            enq_set(50 + i, 1, 60 + i, 0, 1, 0, i);
            look(); tick();
        end
        enq_set(70, 1, 71, 0, 1, 0, 7);
        look(); chk("full_IS_ready", IS_ready, 0); chk("full_iq_count", iq_count, 8); tick();
        look(); chk("full_no_accept", iq_count, 8); tick();
        wb_valid = 1; wb_P_rd = 50; found = 0;
        for (int k = 0; k < 4 && !found; k++) begin
            look();
            if (issue_valid) begin
                chk("full_issue_rob", issue_rob_idx, 0);
                chk("full_ready_during_issue", IS_ready, 0);
                tick();
                wb_valid = 0;
                look();
                chk("full_ready_after", IS_ready, 1);
                chk("full_count_after", iq_count, 7);
                found = 1;
            end else begin
                tick();
                wb_valid = 0;
            end
        end
        chk("full_issue_seen", 32'(found), 1);
        tick();
        idle();
        look(); chk("full_refill", iq_count, 8); tick();
        do_reset();

        // Reset with 5 held entries
        issue_ready = 0;
        for (int i = 0; i < 5; i++) begin
            enq_set(10 + i, 20 + i, 30 + i, 1, 1, 0, i);
            look(); tick();
        end
        enq_valid = 0;
        look(); chk("rst_before", issue_valid, 1); chk("rst_before_cnt", iq_count, 5); tick();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            look(); chk("rst_no_issue_after", issue_valid, 0); tick();
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(399) == 0) do_reset();
            enq_valid = $urandom_range(99) < 60;
            enq_P_rs1 = 7'($urandom_range(15)); enq_P_rs2 = 7'($urandom_range(15));
            enq_P_rd = 7'($urandom_range(127));
            enq_rs1_rdy = $urandom_range(3) == 0; enq_rs2_rdy = $urandom_range(3) == 0;
            enq_fu_sel = 3'($urandom_range(7)); enq_rob_idx = 3'($urandom_range(7));
            wb_valid = $urandom_range(1) == 1; wb_P_rd = 7'($urandom_range(15));
            fu_ready = 8'($urandom);
            issue_ready = $urandom_range(3) != 0;
            mispredict = $urandom_range(49) == 0;
            look(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
